// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, bus mode constants and the
// default transfer width. Also imported by responder-side bench models.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SCK_LO = 3'd2,
    ST_SCK_HI = 3'd3,
    ST_CHAIN  = 3'd4,
    ST_GAP    = 3'd5
  } spi_state_e;

  // Mode 0: SCLK idles low, data sampled on the rising SCLK edge.
  localparam logic        SPI_CPOL   = 1'b0;
  localparam logic        SPI_CPHA   = 1'b0;
  localparam int unsigned SPI_DATA_W = 8;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for the SPI initiator. Reload starts a new phase of
// CLK_DIV cycles; phase_tick marks the last cycle of the running phase.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic reload,
  output logic phase_tick
);

  localparam int unsigned     CW         = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0]   RELOAD_VAL = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count down to zero and park there; reload wins over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= RELOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign phase_tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// SPI initiator, mode 0, MSB first, active-low SSEL. Bytes arrive over a
// valid/ready handshake; the byte clocked in on MISO during the same frame is
// returned on rx_data with a one-cycle rx_valid pulse. tx_last=0 keeps SSEL
// low and waits in CHAIN for the next byte.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = SPI_DATA_W,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned HOLD    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              SCLK,
  output logic              SSEL,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int unsigned   BW       = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam int unsigned   GW       = $clog2(HOLD + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(HOLD - 1);

  if (CLK_DIV < 1 || HOLD < 1 || DATA_W < 2 || SPI_CPHA != 1'b0) begin : g_bad_params
    $error("spi_master: unsupported parameter combination");
  end

  spi_state_e        state;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [BW-1:0]     bit_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              last_q;
  logic              accept;
  logic              div_en;
  logic              div_reload;
  logic              phase_tick;

  assign accept     = tx_valid && tx_ready;
  assign div_en     = (state == ST_LOAD) || (state == ST_SCK_HI) || (state == ST_SCK_LO);
  assign div_reload = accept || phase_tick;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk        (clk),
    .rst        (rst),
    .en         (div_en),
    .reload     (div_reload),
    .phase_tick (phase_tick)
  );

  // Frame sequencer with registered pin and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_sh    <= '0;
      rx_sh    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      last_q   <= 1'b0;
      tx_ready <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
      SCLK     <= SPI_CPOL;
      SSEL     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_CHAIN: begin
          if (accept) begin
            // tx_sh holds the bits still to be sent after the one on MOSI.
            tx_sh    <= {tx_data[DATA_W-2:0], 1'b0};
            MOSI     <= tx_data[DATA_W-1];
            last_q   <= tx_last;
            bit_cnt  <= '0;
            SSEL     <= 1'b0;
            SCLK     <= SPI_CPOL;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD, ST_SCK_LO: begin
          if (phase_tick) begin
            SCLK  <= ~SPI_CPOL;
            rx_sh <= {rx_sh[DATA_W-2:0], MISO};
            state <= ST_SCK_HI;
          end
        end
        ST_SCK_HI: begin
          if (phase_tick) begin
            SCLK <= SPI_CPOL;
            if (bit_cnt == LAST_BIT) begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
              if (last_q) begin
                state <= ST_GAP;
              end else begin
                tx_ready <= 1'b1;
                state    <= ST_CHAIN;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              MOSI    <= tx_sh[DATA_W-1];
              tx_sh   <= {tx_sh[DATA_W-2:0], 1'b0};
              state   <= ST_SCK_LO;
            end
          end
        end
        ST_GAP: begin
          // SSEL is released one cycle after the last falling SCLK edge so
          // SCLK is already low when SSEL moves; then HOLD cycles high.
          if (!SSEL) begin
            SSEL    <= 1'b1;
            MOSI    <= 1'b0;
            gap_cnt <= GAP_LOAD;
          end else if (gap_cnt == '0) begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
